dp_reg_bank: RTL

//  Parametrised single-clock register bank replacing the fixed 64x16 single-port block RAM.

---
 rtl/dp_reg_bank_pkg.sv | 18 +
 rtl/dp_reg_bank_if.sv | 30 +++
 rtl/dp_reg_bank_rd_pipe.sv | 34 +++
 rtl/dp_reg_bank.sv | 119 +++++++++++
 4 files changed

// File: rtl/dp_reg_bank_pkg.sv
// Shared types and constants for the dual-port register bank.
// No logic; no latency.
// No flow control.
package reg_bank_pkg;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_CLEAR = 1'b1
    } state_t;

    localparam int RD_LAT_MIN = 1;
    localparam int RD_LAT_MAX = 2;

    function automatic bit rd_lat_legal(input int lat);
        return (lat >= RD_LAT_MIN) && (lat <= RD_LAT_MAX);
    endfunction

endpackage

// File: rtl/dp_reg_bank_if.sv
// Request/response bundle of the register bank: port A r/w, port B read, clear control.
// Latency set by the bank; no added delay.
// No backpressure: requests are dropped while busy is high.
interface dp_reg_bank_if #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 6
);
    logic              a_en;
    logic              a_we;
    logic [ADDR_W-1:0] a_addr;
    logic [DATA_W-1:0] a_din;
    logic [DATA_W-1:0] a_dout;
    logic              a_valid;
    logic              b_en;
    logic [ADDR_W-1:0] b_addr;
    logic [DATA_W-1:0] b_dout;
    logic              b_valid;
    logic              clr_req;
    logic              busy;

    modport master (
        output a_en, a_we, a_addr, a_din, b_en, b_addr, clr_req,
        input  a_dout, a_valid, b_dout, b_valid, busy
    );

    modport slave (
        input  a_en, a_we, a_addr, a_din, b_en, b_addr, clr_req,
        output a_dout, a_valid, b_dout, b_valid, busy
    );
endinterface

// File: rtl/dp_reg_bank_rd_pipe.sv
// Data+valid delay line appended after the registered array read.
// Latency STAGES cycles; data only advances with its valid, so outputs hold between strobes.
// No backpressure: one result per cycle in and out.
module rd_pipe #(
    parameter int DATA_W = 16,
    parameter int STAGES = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_vld,
    input  logic [DATA_W-1:0] in_dat,
    output logic              out_vld,
    output logic [DATA_W-1:0] out_dat
);
    logic [STAGES-1:0] vld_q;
    logic [DATA_W-1:0] dat_q [STAGES];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_q <= '0;
            for (int i = 0; i < STAGES; i++) dat_q[i] <= '0;
        end else begin
            vld_q[0] <= in_vld;
            if (in_vld) dat_q[0] <= in_dat;
            for (int i = 1; i < STAGES; i++) begin
                vld_q[i] <= vld_q[i-1];
                if (vld_q[i-1]) dat_q[i] <= dat_q[i-1];
            end
        end
    end

    assign out_vld = vld_q[STAGES-1];
    assign out_dat = dat_q[STAGES-1];
endmodule

// File: rtl/dp_reg_bank.sv
// Register bank: port A read/write, port B read-only, with a sequential clear engine.
// Read latency RD_LAT cycles on both ports; writes take effect at the issuing edge.
// No backpressure: requests while busy (clearing) are discarded, in-flight reads complete.
module dp_reg_bank
    import reg_bank_pkg::*;
#(
    parameter int DATA_W      = 16,
    parameter int DEPTH       = 64,
    parameter int ADDR_W      = 6,
    parameter int RD_LAT      = 1,
    parameter int WRITE_FIRST = 1,
    parameter int CLR_ON_RST  = 1
) (
    input  logic            clk,
    input  logic            rst_n,
    dp_reg_bank_if.slave    bus
);
    localparam int              PIPE_STAGES = rd_lat_legal(RD_LAT) ? RD_LAT - 1 : 0;
    localparam logic [ADDR_W:0] DEPTH_X     = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
    localparam state_t          RST_STATE   = (CLR_ON_RST != 0) ? ST_CLEAR : ST_IDLE;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   clr_cnt_q, clr_cnt_d;
    logic                busy, clr_wr;

    logic [DATA_W-1:0]   mem [DEPTH];
    logic                a_in_rng, b_in_rng, a_wr, a_rd, b_rd, b_collide;
    logic [DATA_W-1:0]   a_rdata, b_rdata;
    logic                a_vld_s1, b_vld_s1, a_vld_o, b_vld_o;
    logic [DATA_W-1:0]   a_dat_s1, b_dat_s1, a_dat_o, b_dat_o;

    // Comparison is done one bit wider so DEPTH == 2**ADDR_W works.
    assign a_in_rng  = {1'b0, bus.a_addr} < DEPTH_X;
    assign b_in_rng  = {1'b0, bus.b_addr} < DEPTH_X;
    assign a_wr      = bus.a_en & bus.a_we & ~busy & a_in_rng;
    assign a_rd      = bus.a_en & ~bus.a_we & ~busy;
    assign b_rd      = bus.b_en & ~busy;
    assign b_collide = a_wr & (bus.a_addr == bus.b_addr);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= RST_STATE;
            clr_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            clr_cnt_q <= clr_cnt_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        clr_cnt_d = '0;
        case (state_q)
            ST_IDLE:  if (bus.clr_req) state_d = ST_CLEAR;
            ST_CLEAR: begin
                if (clr_cnt_q == LAST_ADDR) state_d = ST_IDLE;
                else                        clr_cnt_d = clr_cnt_q + 1'b1;
            end
            default:  state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        busy   = (state_q == ST_CLEAR);
        clr_wr = (state_q == ST_CLEAR);
    end

    // Array has no reset so it can map onto block RAM.
    always_ff @(posedge clk) begin
        if (clr_wr)    mem[clr_cnt_q]  <= '0;
        else if (a_wr) mem[bus.a_addr] <= bus.a_din;
    end

    always_comb begin
        a_rdata = a_in_rng ? mem[bus.a_addr] : '0;
        if (!b_in_rng)                          b_rdata = '0;
        else if ((WRITE_FIRST != 0) && b_collide) b_rdata = bus.a_din;
        else                                    b_rdata = mem[bus.b_addr];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_vld_s1 <= 1'b0;
            b_vld_s1 <= 1'b0;
            a_dat_s1 <= '0;
            b_dat_s1 <= '0;
        end else begin
            a_vld_s1 <= a_rd;
            b_vld_s1 <= b_rd;
            if (a_rd) a_dat_s1 <= a_rdata;
            if (b_rd) b_dat_s1 <= b_rdata;
        end
    end

    if (PIPE_STAGES > 0) begin : g_pipe
        rd_pipe #(.DATA_W(DATA_W), .STAGES(PIPE_STAGES)) u_pipe_a (
            .clk(clk), .rst_n(rst_n),
            .in_vld(a_vld_s1), .in_dat(a_dat_s1),
            .out_vld(a_vld_o), .out_dat(a_dat_o)
        );
        rd_pipe #(.DATA_W(DATA_W), .STAGES(PIPE_STAGES)) u_pipe_b (
            .clk(clk), .rst_n(rst_n),
            .in_vld(b_vld_s1), .in_dat(b_dat_s1),
            .out_vld(b_vld_o), .out_dat(b_dat_o)
        );
    end else begin : g_nopipe
        assign a_vld_o = a_vld_s1;
        assign a_dat_o = a_dat_s1;
        assign b_vld_o = b_vld_s1;
        assign b_dat_o = b_dat_s1;
    end

    assign bus.a_valid = a_vld_o;
    assign bus.a_dout  = a_dat_o;
    assign bus.b_valid = b_vld_o;
    assign bus.b_dout  = b_dat_o;
    assign bus.busy    = busy;
endmodule
